// File: rtl/main_mem_responder.sv
// Block-organised main memory shared by the data and instruction cache refill ports.
// Data port wins arbitration; every access takes a fixed number of busy cycles before a one-cycle DONE.
module main_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 5
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         I_READ,
   input  logic [27:0]  I_ADDRESS,
   output logic [127:0] I_READDATA,
   output logic         I_BUSYWAIT,
   input  logic         D_READ,
   input  logic         D_WRITE,
   input  logic [27:0]  D_ADDRESS,
   input  logic [127:0] D_WRITEDATA,
   output logic [127:0] D_READDATA,
   output logic         D_BUSYWAIT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_grant_d;
   logic            r_write;
   logic [AW-1:0]   r_idx;
   logic [127:0]    r_wdata;
   logic [127:0]    r_mem [DEPTH] = '{default: '0};

   logic            w_d_req;
   logic            w_any_req;
   logic            w_commit;
   logic            w_unused_addr;

   assign w_d_req   = D_READ | D_WRITE;
   assign w_any_req = w_d_req | I_READ;
   assign w_commit  = (r_state == ST_BUSY) && (r_cnt == '0);

   // Upper address bits only alias onto the same block.
   assign w_unused_addr = ^{I_ADDRESS[27:AW], D_ADDRESS[27:AW]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req) w_next = ST_BUSY;
         ST_BUSY: if (r_cnt == '0) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_any_req)
            r_cnt <= CW'(LATENCY - 1);
         else if (r_state == ST_BUSY && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (r_state == ST_IDLE && w_any_req) begin
         r_grant_d <= w_d_req;
         r_write   <= D_WRITE;
         r_idx     <= w_d_req ? D_ADDRESS[AW-1:0] : I_ADDRESS[AW-1:0];
         r_wdata   <= D_WRITEDATA;
      end
   end

   // A reset landing on the commit edge aborts the access, so the write is gated.
   always_ff @(posedge CLK) begin
      if (!RESET && w_commit && r_write)
         r_mem[r_idx] <= r_wdata;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         I_READDATA <= '0;
         D_READDATA <= '0;
      end else if (w_commit && !r_write) begin
         if (r_grant_d)
            D_READDATA <= r_mem[r_idx];
         else
            I_READDATA <= r_mem[r_idx];
      end
   end

   assign D_BUSYWAIT = w_d_req & ~((r_state == ST_DONE) & r_grant_d);
   assign I_BUSYWAIT = I_READ  & ~((r_state == ST_DONE) & ~r_grant_d);

endmodule
